// File: rtl/si_tag_lane_serializer.sv
// si_tag_lane_serializer
// Drains the kept lanes of a multi-lane tag beat onto a single-tag AXI-Stream
// output, one tag per cycle in ascending lane order. The converter is held off
// while a beat is draining.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   s_axis_tvalid    input beat valid
//   s_axis_tready    input beat accepted (combinational from state and m_axis_tready)
//   s_axis_tagtime   NUMBER_OF_WORDS x TIME_WIDTH lane tag times, lane 0 in the LSBs
//   s_axis_channel   NUMBER_OF_WORDS x 6 signed lane channels, lane 0 in the LSBs
//   s_axis_tkeep     per-lane valid mask
//   m_axis_tvalid    output tag valid
//   m_axis_tready    downstream ready
//   m_axis_tagtime   tag time of the current tag
//   m_axis_channel   channel of the current tag
//   m_axis_tlane     source lane of the current tag
//   m_axis_tlast     current tag is the last kept lane of its beat
//   tag_count        output handshake counter, wraps modulo 2^32
module si_tag_lane_serializer #(
    parameter int unsigned NUMBER_OF_WORDS = 4,
    parameter int unsigned LANE_WIDTH      = (NUMBER_OF_WORDS > 1) ? $clog2(NUMBER_OF_WORDS) : 1,
    parameter int unsigned TIME_WIDTH      = 64
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    input  logic [NUMBER_OF_WORDS*TIME_WIDTH-1:0] s_axis_tagtime,
    input  logic [NUMBER_OF_WORDS*6-1:0]          s_axis_channel,
    input  logic [NUMBER_OF_WORDS-1:0]            s_axis_tkeep,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic [TIME_WIDTH-1:0]                 m_axis_tagtime,
    output logic signed [5:0]                     m_axis_channel,
    output logic [LANE_WIDTH-1:0]                 m_axis_tlane,
    output logic                                  m_axis_tlast,
    output logic [31:0]                           tag_count
);

    localparam int unsigned N  = NUMBER_OF_WORDS;
    localparam int unsigned CW = 6;

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [N-1:0]            pend;
    logic [N-1:0]            pend_nxt;
    logic [N*TIME_WIDTH-1:0] hold_time;
    logic [N*CW-1:0]         hold_chan;

    logic                    in_hs;
    logic                    out_hs;
    logic                    single;
    logic [LANE_WIDTH-1:0]   lane_nxt;
    logic [TIME_WIDTH-1:0]   time_nxt;
    logic [CW-1:0]           chan_nxt;
    logic                    last_nxt;

    // Index of the lowest set bit; zero for an empty mask.
    function automatic logic [LANE_WIDTH-1:0] lowest_lane(input logic [N-1:0] mask);
        lowest_lane = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest_lane = LANE_WIDTH'(i);
            end
        end
    endfunction

    // Exactly one bit set: clearing the lowest bit leaves nothing.
    function automatic logic one_hot(input logic [N-1:0] mask);
        one_hot = (mask != '0) && ((mask & (mask - N'(1))) == '0);
    endfunction

    // Handshakes and input back-pressure.
    always_comb begin
        single        = one_hot(pend);
        s_axis_tready = (state == EMPTY) || (single && m_axis_tready);
        in_hs         = s_axis_tvalid && s_axis_tready;
        out_hs        = m_axis_tvalid && m_axis_tready;
    end

    // Next pending mask and the tag that becomes current after the edge.
    // A load wins over the bit-clear: it only coincides with consuming the final bit.
    always_comb begin
        pend_nxt = pend;
        if (in_hs) begin
            pend_nxt = s_axis_tkeep;
        end else if (out_hs) begin
            pend_nxt = pend & (pend - N'(1));
        end

        state_nxt = (pend_nxt != '0) ? DRAIN : EMPTY;
        lane_nxt  = lowest_lane(pend_nxt);
        last_nxt  = one_hot(pend_nxt);

        // Lane mux reads the incoming beat directly on a load so the first tag
        // appears the cycle after acceptance.
        time_nxt = '0;
        chan_nxt = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (lane_nxt == LANE_WIDTH'(i)) begin
                if (in_hs) begin
                    time_nxt = s_axis_tagtime[i*TIME_WIDTH +: TIME_WIDTH];
                    chan_nxt = s_axis_channel[i*CW +: CW];
                end else begin
                    time_nxt = hold_time[i*TIME_WIDTH +: TIME_WIDTH];
                    chan_nxt = hold_chan[i*CW +: CW];
                end
            end
        end
    end

    // State, holding register, counter and registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= EMPTY;
            pend           <= '0;
            hold_time      <= '0;
            hold_chan      <= '0;
            tag_count      <= '0;
            m_axis_tvalid  <= 1'b0;
            m_axis_tlast   <= 1'b0;
            m_axis_tagtime <= '0;
            m_axis_channel <= '0;
            m_axis_tlane   <= '0;
        end else begin
            state         <= state_nxt;
            pend          <= pend_nxt;
            m_axis_tvalid <= (pend_nxt != '0);
            m_axis_tlast  <= last_nxt;
            if (in_hs) begin
                hold_time <= s_axis_tagtime;
                hold_chan <= s_axis_channel;
            end
            if (out_hs) begin
                tag_count <= tag_count + 32'd1;
            end
            // Data fields only move when a tag is presented; idle and empty
            // beats leave them untouched.
            if (pend_nxt != '0) begin
                m_axis_tagtime <= time_nxt;
                m_axis_channel <= chan_nxt;
                m_axis_tlane   <= lane_nxt;
            end
        end
    end

endmodule

// File: tb/tb_si_tag_lane_serializer.sv
module tb_si_tag_lane_serializer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Four-lane instance
    logic         s_tvalid;
    logic         s_tready;
    logic [255:0] s_time;
    logic [23:0]  s_chan;
    logic [3:0]   s_keep;
    logic         m_tvalid;
    logic         m_tready;
    logic [63:0]  m_time;
    logic [5:0]   m_chan;
    logic [1:0]   m_lane;
    logic         m_tlast;
    logic [31:0]  tag_count;

    // Single-lane instance
    logic         s1_tvalid;
    logic         s1_tready;
    logic [63:0]  s1_time;
    logic [5:0]   s1_chan;
    logic [0:0]   s1_keep;
    logic         m1_tvalid;
    logic         m1_tready;
    logic [63:0]  m1_time;
    logic [5:0]   m1_chan;
    logic [0:0]   m1_lane;
    logic         m1_tlast;
    logic [31:0]  tag_count1;

    si_tag_lane_serializer #(.NUMBER_OF_WORDS(4), .TIME_WIDTH(64)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tagtime(s_time), .s_axis_channel(s_chan), .s_axis_tkeep(s_keep),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tagtime(m_time), .m_axis_channel(m_chan), .m_axis_tlane(m_lane),
        .m_axis_tlast(m_tlast), .tag_count(tag_count)
    );

    si_tag_lane_serializer #(.NUMBER_OF_WORDS(1), .TIME_WIDTH(64)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready),
        .s_axis_tagtime(s1_time), .s_axis_channel(s1_chan), .s_axis_tkeep(s1_keep),
        .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready),
        .m_axis_tagtime(m1_time), .m_axis_channel(m1_chan), .m_axis_tlane(m1_lane),
        .m_axis_tlast(m1_tlast), .tag_count(tag_count1)
    );

    // Reference model: the tags still owed by the current beat, in emission order.
    typedef struct {
        logic [1:0]  lane;
        logic [63:0] t;
        logic [5:0]  ch;
    } tag_t;

    tag_t        q[$];
    tag_t        q1[$];
    logic [31:0] mcount;
    logic [31:0] mcount1;
    bit          last_in_hs;
    bit          last_in1;
    int          total;
    int          bad;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle();
        bit v;
        bit v1;
        v  = (q.size() != 0);
        v1 = (q1.size() != 0);
        chk("m_tvalid", 64'(m_tvalid), 64'(v));
        chk("s_tready", 64'(s_tready), 64'(q.size() == 0 || (q.size() == 1 && m_tready)));
        chk("tag_count", 64'(tag_count), 64'(mcount));
        if (v) begin
            chk("m_tagtime", m_time, q[0].t);
            chk("m_channel", 64'(m_chan), 64'(q[0].ch));
            chk("m_tlane", 64'(m_lane), 64'(q[0].lane));
            chk("m_tlast", 64'(m_tlast), 64'(q.size() == 1));
        end else begin
            chk("m_tlast_idle", 64'(m_tlast), 64'd0);
        end
        chk("m1_tvalid", 64'(m1_tvalid), 64'(v1));
        chk("s1_tready", 64'(s1_tready), 64'(q1.size() == 0 || (q1.size() == 1 && m1_tready)));
        chk("tag_count1", 64'(tag_count1), 64'(mcount1));
        if (v1) begin
            chk("m1_tagtime", m1_time, q1[0].t);
            chk("m1_channel", 64'(m1_chan), 64'(q1[0].ch));
            chk("m1_tlane", 64'(m1_lane), 64'd0);
            chk("m1_tlast", 64'(m1_tlast), 64'd1);
        end
    endtask

    // Compare on the falling edge, then advance the model across the rising edge.
    task automatic step();
        bit in_hs;
        bit out_hs;
        bit in1;
        bit out1;
        @(negedge clk);
        check_cycle();
        in_hs  = s_tvalid && (q.size() == 0 || (q.size() == 1 && m_tready));
        out_hs = (q.size() != 0) && m_tready;
        in1    = s1_tvalid && (q1.size() == 0 || (q1.size() == 1 && m1_tready));
        out1   = (q1.size() != 0) && m1_tready;
        @(posedge clk);
        if (out_hs) begin
            void'(q.pop_front());
            mcount++;
        end
        if (in_hs) begin
            q.delete();
            for (int i = 0; i < 4; i++) begin
                if (s_keep[i]) q.push_back('{lane: 2'(i), t: s_time[i*64 +: 64], ch: s_chan[i*6 +: 6]});
            end
        end
        if (out1) begin
            void'(q1.pop_front());
            mcount1++;
        end
        if (in1) begin
            q1.delete();
            if (s1_keep[0]) q1.push_back('{lane: 2'd0, t: s1_time, ch: s1_chan});
        end
        last_in_hs = in_hs;
        last_in1   = in1;
        #1;
    endtask

    task automatic set_beat(input logic [3:0] keep, input logic [23:0] chans);
        s_keep = keep;
        s_chan = chans;
        for (int i = 0; i < 4; i++) s_time[i*64 +: 64] = {32'(i + 1), 32'($urandom())};
    endtask

    task automatic send();
        int n;
        n = 0;
        s_tvalid = 1'b1;
        do begin
            step();
            n++;
        end while (!last_in_hs && n < 40);
        if (!last_in_hs) chk("send_timeout", 64'd0, 64'd1);
        s_tvalid = 1'b0;
    endtask

    // Reset asserted mid-cycle; outputs must fall without waiting for a clock.
    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_count", 64'(tag_count), 64'd0);
        chk("rst_sready", 64'(s_tready), 64'd1);
        q.delete();
        q1.delete();
        mcount    = '0;
        mcount1   = '0;
        s_tvalid  = 1'b0;
        s1_tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0;
        mcount = '0; mcount1 = '0;
        last_in_hs = 1'b0; last_in1 = 1'b0;
        rst_n = 1'b0;
        s_tvalid = 1'b0; s_time = '0; s_chan = '0; s_keep = '0; m_tready = 1'b1;
        s1_tvalid = 1'b0; s1_time = '0; s1_chan = '0; s1_keep = '0; m1_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("init_tvalid", 64'(m_tvalid), 64'd0);
        chk("init_sready", 64'(s_tready), 64'd1);
        chk("init_count", 64'(tag_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sparse beat: channels {4,-3,2,1} on lanes 3..0, keep 1011.
        m_tready = 1'b1;
        set_beat(4'b1011, {6'd4, 6'h3D, 6'd2, 6'd1});
        send();
        chk("t1_c1_lane", 64'(m_lane), 64'd0);
        chk("t1_c1_chan", 64'(m_chan), 64'd1);
        chk("t1_c1_last", 64'(m_tlast), 64'd0);
        chk("t1_c1_srdy", 64'(s_tready), 64'd0);
        step();
        chk("t1_c2_lane", 64'(m_lane), 64'd1);
        chk("t1_c2_chan", 64'(m_chan), 64'd2);
        chk("t1_c2_last", 64'(m_tlast), 64'd0);
        chk("t1_c2_srdy", 64'(s_tready), 64'd0);
        step();
        chk("t1_c3_lane", 64'(m_lane), 64'd3);
        chk("t1_c3_chan", 64'(m_chan), 64'd4);
        chk("t1_c3_last", 64'(m_tlast), 64'd1);
        chk("t1_c3_srdy", 64'(s_tready), 64'd1);
        step();
        chk("t1_count", 64'(tag_count), 64'd3);

        // Three full beats back to back: third accepted on the 8th handshake.
        do_reset();
        m_tready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            set_beat(4'hF, 24'($urandom()));
            send();
        end
        chk("t2_count_mid", 64'(tag_count), 64'd8);
        repeat (5) step();
        chk("t2_count", 64'(tag_count), 64'd12);

        // Back-pressure on a two-lane beat.
        do_reset();
        m_tready = 1'b0;
        set_beat(4'b0110, 24'($urandom()));
        send();
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_lane", 64'(m_lane), 64'd1);
            chk("t3_hold_srdy", 64'(s_tready), 64'd0);
            step();
        end
        m_tready = 1'b1;
        chk("t3_rel_lane", 64'(m_lane), 64'd1);
        chk("t3_rel_srdy", 64'(s_tready), 64'd0);
        step();
        chk("t3_l2_lane", 64'(m_lane), 64'd2);
        chk("t3_l2_last", 64'(m_tlast), 64'd1);
        chk("t3_l2_srdy", 64'(s_tready), 64'd1);
        step();
        chk("t3_count", 64'(tag_count), 64'd2);

        // Empty beat between two single-lane beats.
        do_reset();
        m_tready = 1'b1;
        set_beat(4'b0001, 24'($urandom()));
        send();
        set_beat(4'b0000, 24'($urandom()));
        send();
        set_beat(4'b0001, 24'($urandom()));
        send();
        repeat (4) step();
        chk("t4_count", 64'(tag_count), 64'd2);

        // Reset while lanes 2 and 3 are pending, then a lane-3-only beat.
        do_reset();
        m_tready = 1'b0;
        set_beat(4'b1100, 24'($urandom()));
        send();
        step();
        do_reset();
        m_tready = 1'b1;
        set_beat(4'b1000, {6'd5, 6'd9, 6'd9, 6'd9});
        send();
        chk("t5_tvalid", 64'(m_tvalid), 64'd1);
        chk("t5_lane", 64'(m_lane), 64'd3);
        chk("t5_chan", 64'(m_chan), 64'd5);
        chk("t5_last", 64'(m_tlast), 64'd1);
        step();
        step();

        // Random traffic on both instances; AXI-legal source (payload held until accepted).
        last_in_hs = 1'b0;
        last_in1   = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!s_tvalid || last_in_hs) begin
                s_tvalid = ($urandom_range(0, 2) != 0);
                set_beat(4'($urandom_range(0, 15)), 24'($urandom()));
            end
            if (!s1_tvalid || last_in1) begin
                s1_tvalid = ($urandom_range(0, 2) != 0);
                s1_keep   = 1'($urandom_range(0, 3) != 0);
                s1_chan   = 6'($urandom());
                s1_time   = {32'($urandom()), 32'($urandom())};
            end
            m_tready  = ($urandom_range(0, 3) != 0);
            m1_tready = ($urandom_range(0, 3) != 0);
            step();
        end
        s_tvalid  = 1'b0;
        s1_tvalid = 1'b0;
        m_tready  = 1'b1;
        m1_tready = 1'b1;
        repeat (8) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
